spirit_line_scanner: RTL and testbench
======================================

# spirit_line_scanner

Per-scanline sprite (spirit) evaluation controller for the spirit memory. On each line-start pulse it sweeps all spirit entries through the spirit memory's read port, one index per cycle. It tests each position struct against the current line Y and pushes up to `MAX_HITS` visible spirits into an internal hit FIFO. The pixel compositor drains that FIFO over a valid/ready handshake.

## Interface
- `SPIRIT_COUNT`, 512: number of entries swept; index width is 9 bits.
- `MAX_HITS`, 16: maximum hits per line; also the hit FIFO depth (power of two).
- `clk` input, 1 bit: single clock for all logic.
- `i_rst_n` input, 1 bit: reset, asynchronous, active-low.
- `i_line_start` input, 1 bit: one-cycle pulse that starts the scan for `i_line_y`.
- `i_line_y` input, 16 bits: current line; sampled only when `i_line_start` = 1.
- `o_spirit_idx` output, 9 bits: read index to the spirit memory. Read latency is 1 cycle.
- `i_spirit_struct` input, 64 bits: position struct from the spirit memory.
  - [15:0] X
  - [31:16] Y
  - [39:32] width
  - [47:40] height
  - [63:48] zero
- `o_busy` output, 1 bit: scan in progress.
- `o_done` output, 1 bit: one-cycle pulse when the scan ends.
- `o_overflow` output, 1 bit: more than `MAX_HITS` hits on this line. Sticky until the next `i_line_start`.
- `o_hit_count` output, 5 bits: hits accepted this line, range 0..`MAX_HITS`.
- `o_hit_valid` output, 1 bit: FIFO head is valid.
- `i_hit_ready` input, 1 bit: consumer pops the head when `o_hit_valid` & `i_hit_ready`.
- `o_hit_idx` output, 9 bits: spirit index of the head entry.
- `o_hit_x` output, 16 bits: X of the head entry.
- `o_hit_row` output, 8 bits: row within the spirit, `line_y - Y`.
- `o_hit_width` output, 8 bits: width of the head entry.

## Operation
- FSM states: IDLE, SCAN, FLUSH.
  - IDLE → SCAN on `i_line_start`.
  - SCAN → FLUSH after index `SPIRIT_COUNT-1` has been issued, or on early exit (see Configuration).
  - FLUSH → IDLE after one cycle, pulsing `o_done`.
- On `i_line_start`:
  - latch `i_line_y`;
  - clear the FIFO, `o_hit_count` and `o_overflow`;
  - set `o_spirit_idx` = 0 and enter SCAN.
- Restart: `i_line_start` in SCAN or FLUSH restarts the scan identically. The in-flight read is discarded and no `o_done` is emitted for the aborted line.
- SCAN: `o_spirit_idx` increments by 1 each cycle. A valid-tag pipeline register tracks which index the returning data belongs to.
- Hit test on returned data, in 17-bit unsigned arithmetic with no wrap-around:
  - width ≠ 0;
  - height ≠ 0;
  - `line_y` ≥ Y;
  - (`line_y` − Y) < height.
- On a hit with `o_hit_count` < `MAX_HITS`: push {idx, X, `line_y`−Y [7:0], width} and increment `o_hit_count`.
- On a hit with `o_hit_count` = `MAX_HITS`: drop the entry and set `o_overflow`.
- FIFO never overflows: at most `MAX_HITS` pushes per line, and the FIFO is cleared each line.
- Simultaneous push and pop: occupancy is unchanged, and both operations take effect.
- Pop on an empty FIFO is ignored.
- FIFO entries survive FLUSH/IDLE until the next `i_line_start` clears them.

## Timing
- Reset values: all outputs 0, FSM in IDLE, FIFO empty.
- `i_line_start` high in cycle 0:
  - `o_busy` = 1 and `o_spirit_idx` = 0 in cycle 1;
  - index k is presented in cycle 1+k, and its data returns in cycle 2+k;
  - a hit on index k sets `o_hit_valid` in cycle 3+k at the earliest.
- Full sweep: last index issued in cycle 512, `o_done` = 1 and `o_busy` = 0 in cycle 514.
- Head outputs are registered and stable while `o_hit_valid` = 1 and `i_hit_ready` = 0.
- Reset asserted mid-scan returns to the reset state immediately; no `o_done` pulse.

## Configuration
- `SPIRIT_SCAN_EARLY_EXIT_EN` defined:
  - the (`MAX_HITS`+1)-th hit sets `o_overflow` and moves SCAN → FLUSH in the next cycle;
  - `o_done` follows one cycle later, so the scan ends early.
- Not defined:
  - the sweep always covers all `SPIRIT_COUNT` entries;
  - extra hits are dropped with `o_overflow` set;
  - `o_done` always occurs in cycle 514.

## Test plan
- Single hit.
  - Stimulus: entry 5 = {X=100, Y=10, w=8, h=4}, all others zero; line_y=12; `i_hit_ready`=1.
  - Response: one hit {idx=5, x=100, row=2, w=8}; `o_hit_count`=1; `o_done` in cycle 514.
- Vertical boundaries, same entry 5.
  - line_y=13 hits with row=3.
  - line_y=14 misses.
  - line_y=9 misses.
- Overflow.
  - Stimulus: 20 entries covering line 0.
  - Response: exactly 16 hits, for idx 0..15 in order; `o_overflow`=1.
  - With `SPIRIT_SCAN_EARLY_EXIT_EN`: `o_done` in cycle 19.
  - Without it: `o_done` in cycle 514.
- Backpressure.
  - Stimulus: `i_hit_ready`=0 throughout the scan, 3 hits, then `i_hit_ready`=1.
  - Response: three entries drain in index order; `o_hit_valid` falls after the third pop.
- Restart.
  - Stimulus: second `i_line_start` in cycle 200.
  - Response: FIFO and counters cleared, `o_spirit_idx`=0 in cycle 201, a single `o_done` in cycle 714.
- Reset mid-scan.
  - Stimulus: `i_rst_n` low in cycle 50.
  - Response: all outputs 0 immediately; no `o_done`.

Source files
------------

// File: rtl/spirit_line_scanner.sv
// -----------------------------------------------------------------------------
// spirit_line_scanner
//
// Per-scanline spirit (sprite) evaluation controller. A line-start pulse sweeps
// every spirit entry through the spirit memory read port, one index per cycle.
// Each returned position struct is tested against the current line Y. Up to
// MAX_HITS visible spirits are pushed into an internal hit FIFO, which the pixel
// compositor drains over a valid/ready handshake.
//
// Optional feature macro: SPIRIT_SCAN_EARLY_EXIT_EN
//   defined   : the (MAX_HITS+1)-th hit ends the scan early.
//   undefined : the sweep always covers all SPIRIT_COUNT entries.
//
// Ports:
//   clk              clock
//   i_rst_n          asynchronous active-low reset
//   i_line_start     one-cycle pulse, starts (or restarts) a line scan
//   i_line_y         line number, sampled with i_line_start
//   o_spirit_idx     read index to the spirit memory (1-cycle read latency)
//   i_spirit_struct  position struct {zero[63:48], h, w, Y, X}
//   o_busy           scan in progress
//   o_done           one-cycle pulse when the scan ends
//   o_overflow       more than MAX_HITS hits this line (sticky per line)
//   o_hit_count      hits accepted this line
//   o_hit_valid      FIFO head valid
//   i_hit_ready      consumer pops the head on valid & ready
//   o_hit_idx/x/row/width  head entry fields
// -----------------------------------------------------------------------------
module spirit_line_scanner #(
    parameter  int SPIRIT_COUNT = 512,
    parameter  int MAX_HITS     = 16,
    localparam int IDX_W        = $clog2(SPIRIT_COUNT),
    localparam int CNT_W        = $clog2(MAX_HITS + 1),
    localparam int PTR_W        = $clog2(MAX_HITS)
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_line_start,
    input  logic [15:0]      i_line_y,
    output logic [IDX_W-1:0] o_spirit_idx,
    input  logic [63:0]      i_spirit_struct,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overflow,
    output logic [CNT_W-1:0] o_hit_count,
    output logic             o_hit_valid,
    input  logic             i_hit_ready,
    output logic [IDX_W-1:0] o_hit_idx,
    output logic [15:0]      o_hit_x,
    output logic [7:0]       o_hit_row,
    output logic [7:0]       o_hit_width
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FLUSH
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [15:0]      x;
        logic [7:0]       row;
        logic [7:0]       width;
    } hit_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPIRIT_COUNT - 1);
    localparam logic [CNT_W-1:0] HIT_CAP  = CNT_W'(MAX_HITS);

    state_t           state_q, state_d;
    logic [15:0]      line_y_q;
    logic [IDX_W-1:0] idx_q;
    logic             issue_q;      // an index is being presented this cycle
    logic             tag_vld_q;    // returning data belongs to a live index
    logic [IDX_W-1:0] tag_idx_q;    // index the returning data belongs to
    logic [CNT_W-1:0] hit_cnt_q;
    logic             ovf_q;

    hit_t             fifo_mem [MAX_HITS];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] occ_q;

    // ---------------------------------------------------------------- hit test
    logic [15:0] sp_x, sp_y;
    logic [7:0]  sp_w, sp_h;
    logic [16:0] dy;
    logic        is_hit, room, push, drop, pop, last_return, early_stop;
    logic        unused_bits;
    hit_t        push_entry, head;

    assign sp_x = i_spirit_struct[15:0];
    assign sp_y = i_spirit_struct[31:16];
    assign sp_w = i_spirit_struct[39:32];
    assign sp_h = i_spirit_struct[47:40];
    assign unused_bits = ^i_spirit_struct[63:48];

    // 17-bit arithmetic: the >= test guards the subtraction, so dy never wraps.
    assign dy     = {1'b0, line_y_q} - {1'b0, sp_y};
    assign is_hit = tag_vld_q && (sp_w != 8'd0) && (sp_h != 8'd0)
                    && ({1'b0, line_y_q} >= {1'b0, sp_y})
                    && (dy < 17'(sp_h));

    assign room        = hit_cnt_q < HIT_CAP;
    assign push        = is_hit && room;
    assign drop        = is_hit && !room;
    assign pop         = (occ_q != '0) && i_hit_ready;
    assign last_return = tag_vld_q && (tag_idx_q == LAST_IDX);

`ifdef SPIRIT_SCAN_EARLY_EXIT_EN
    assign early_stop = (state_q == ST_SCAN) && drop;
`else
    assign early_stop = 1'b0;
`endif

    assign push_entry = '{idx: tag_idx_q, x: sp_x, row: dy[7:0], width: sp_w};

    // --------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (i_line_start) begin
            state_d = ST_SCAN;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                // Stay in SCAN until the last index's data has been tested.
                ST_SCAN:  if (last_return || early_stop) state_d = ST_FLUSH;
                ST_FLUSH: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // A restart landing on the FLUSH cycle suppresses the aborted line's done.
    always_comb begin
        o_busy = (state_q == ST_SCAN);
        o_done = (state_q == ST_FLUSH) && !i_line_start;
    end

    // ---------------------------------------------------------- scan datapath
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            line_y_q  <= '0;
            idx_q     <= '0;
            issue_q   <= 1'b0;
            tag_vld_q <= 1'b0;
            tag_idx_q <= '0;
            hit_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else if (i_line_start) begin
            // Dropping tag_vld discards any read still in flight on a restart.
            line_y_q  <= i_line_y;
            idx_q     <= '0;
            issue_q   <= 1'b1;
            tag_vld_q <= 1'b0;
            tag_idx_q <= '0;
            hit_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            tag_vld_q <= issue_q;
            tag_idx_q <= idx_q;
            if (issue_q) begin
                if (idx_q == LAST_IDX) issue_q <= 1'b0;
                else                   idx_q   <= idx_q + IDX_W'(1);
            end
            if (early_stop) issue_q <= 1'b0;
            if (push) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            if (drop) ovf_q     <= 1'b1;
        end
    end

    assign o_spirit_idx = idx_q;
    assign o_hit_count  = hit_cnt_q;
    assign o_overflow   = ovf_q;

    // ---------------------------------------------------------------- hit FIFO
    // At most MAX_HITS pushes per line and a clear at every line start, so the
    // FIFO can never be written while full.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else if (i_line_start) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ_q <= occ_q + CNT_W'(1);
                2'b01:   occ_q <= occ_q - CNT_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; its contents are only observed
    // through the occupancy-gated head outputs below.
    always_ff @(posedge clk) begin
        if (push && !i_line_start) fifo_mem[wr_ptr_q] <= push_entry;
    end

    // Head is read from registers at a registered pointer, so it is stable
    // while the consumer holds off.
    always_comb begin
        head        = fifo_mem[rd_ptr_q];
        o_hit_valid = (occ_q != '0);
        o_hit_idx   = o_hit_valid ? head.idx   : '0;
        o_hit_x     = o_hit_valid ? head.x     : '0;
        o_hit_row   = o_hit_valid ? head.row   : '0;
        o_hit_width = o_hit_valid ? head.width : '0;
    end

endmodule

// File: tb/tb_spirit_line_scanner.sv
module tb_spirit_line_scanner;

    typedef logic [40:0] hit_t; // {idx[8:0], x[15:0], row[7:0], width[7:0]}

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_line_start;
    logic [15:0] i_line_y;
    logic [8:0]  o_spirit_idx;
    logic [63:0] i_spirit_struct;
    logic        o_busy, o_done, o_overflow;
    logic [4:0]  o_hit_count;
    logic        o_hit_valid, i_hit_ready;
    logic [8:0]  o_hit_idx;
    logic [15:0] o_hit_x;
    logic [7:0]  o_hit_row, o_hit_width;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] spr [512];
    hit_t        got [$];

    // Per-run observations
    int   done_cnt, done_cyc, first_valid_cyc;
    logic busy_at_done, busy_c1, ovf_c1;
    logic [8:0] idx_c1, idx_rs;
    logic [4:0] cnt_rs;
    logic valid_before_rs, valid_rs;

    spirit_line_scanner dut (
        .clk             (clk),
        .i_rst_n         (i_rst_n),
        .i_line_start    (i_line_start),
        .i_line_y        (i_line_y),
        .o_spirit_idx    (o_spirit_idx),
        .i_spirit_struct (i_spirit_struct),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_overflow      (o_overflow),
        .o_hit_count     (o_hit_count),
        .o_hit_valid     (o_hit_valid),
        .i_hit_ready     (i_hit_ready),
        .o_hit_idx       (o_hit_idx),
        .o_hit_x         (o_hit_x),
        .o_hit_row       (o_hit_row),
        .o_hit_width     (o_hit_width)
    );

    always #5 clk = ~clk;

    // Spirit memory model: one-cycle registered read.
    always @(posedge clk) i_spirit_struct <= spr[o_spirit_idx];

    function automatic logic [63:0] mk(input logic [15:0] x, input logic [15:0] y,
                                       input logic [7:0] w, input logic [7:0] h);
        return {16'd0, h, w, y, x};
    endfunction

    function automatic hit_t eh(input logic [8:0] idx, input logic [15:0] x,
                                input logic [7:0] row, input logic [7:0] w);
        return {idx, x, row, w};
    endfunction

    function automatic logic [58:0] all_outs();
        return {o_busy, o_done, o_overflow, o_hit_count, o_hit_valid, o_spirit_idx,
                o_hit_idx, o_hit_x, o_hit_row, o_hit_width};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) spr[i] = 64'd0;
    endtask

    // Cycle 0 is the cycle in which i_line_start is high; outputs are sampled
    // 1 time unit after each falling edge.
    task automatic run_scan(input logic [15:0] ly, input logic rdy, input int ncyc,
                            input int restart_cyc);
        got.delete();
        done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; busy_at_done = 1'b0;
        @(negedge clk);
        i_line_start = 1'b1; i_line_y = ly; i_hit_ready = rdy;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            i_line_start = (c == restart_cyc);
            #1;
            if (c == 1) begin
                idx_c1 = o_spirit_idx; busy_c1 = o_busy; ovf_c1 = o_overflow;
            end
            if (c == restart_cyc) valid_before_rs = o_hit_valid;
            if (c == restart_cyc + 1) begin
                idx_rs = o_spirit_idx; cnt_rs = o_hit_count; valid_rs = o_hit_valid;
            end
            if (o_done) begin
                done_cnt++; done_cyc = c; busy_at_done = o_busy;
            end
            if (o_hit_valid && first_valid_cyc < 0) first_valid_cyc = c;
            if (o_hit_valid && i_hit_ready)
                got.push_back({o_hit_idx, o_hit_x, o_hit_row, o_hit_width});
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_line_start = 1'b0; i_line_y = '0; i_hit_ready = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (all_outs() !== 59'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        @(negedge clk); i_rst_n = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (all_outs() !== 59'd0) begin
            n_fail++; $display("FAIL idle_outputs: got %h expected 0", all_outs());
        end
    endtask

    task automatic test_single_hit();
        clear_mem();
        spr[5] = mk(16'd100, 16'd10, 8'd8, 8'd4);
        run_scan(16'd12, 1'b1, 520, -1);
        n_checks++;
        if (busy_c1 !== 1'b1 || idx_c1 !== 9'd0) begin
            n_fail++; $display("FAIL single_cycle1: busy=%b idx=%0d expected busy=1 idx=0", busy_c1, idx_c1);
        end
        n_checks++;
        if (got.size() !== 1) begin
            n_fail++; $display("FAIL single_hit_count_popped: got %0d expected 1", got.size());
        end else begin
            n_checks++;
            if (got[0] !== eh(9'd5, 16'd100, 8'd2, 8'd8)) begin
                n_fail++; $display("FAIL single_hit_entry: got %h expected %h", got[0], eh(9'd5, 16'd100, 8'd2, 8'd8));
            end
        end
        n_checks++;
        if (first_valid_cyc !== 8) begin
            n_fail++; $display("FAIL single_hit_latency: got %0d expected 8", first_valid_cyc);
        end
        n_checks++;
        if (o_hit_count !== 5'd1) begin
            n_fail++; $display("FAIL single_hit_count: got %0d expected 1", o_hit_count);
        end
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== 514 || busy_at_done !== 1'b0) begin
            n_fail++; $display("FAIL single_done: cnt=%0d cyc=%0d busy=%b expected 1/514/0", done_cnt, done_cyc, busy_at_done);
        end
    endtask

    task automatic test_vertical();
        clear_mem();
        spr[5] = mk(16'd100, 16'd10, 8'd8, 8'd4);
        run_scan(16'd13, 1'b1, 520, -1);
        n_checks++;
        if (got.size() !== 1 || o_hit_count !== 5'd1) begin
            n_fail++; $display("FAIL vert_last_row_count: got %0d expected 1", got.size());
        end else begin
            n_checks++;
            if (got[0] !== eh(9'd5, 16'd100, 8'd3, 8'd8)) begin
                n_fail++; $display("FAIL vert_last_row_entry: got %h expected %h", got[0], eh(9'd5, 16'd100, 8'd3, 8'd8));
            end
        end
        run_scan(16'd14, 1'b1, 520, -1);
        n_checks++;
        if (got.size() !== 0 || o_hit_count !== 5'd0) begin
            n_fail++; $display("FAIL vert_below: got %0d hits expected 0", got.size());
        end
        run_scan(16'd9, 1'b1, 520, -1);
        n_checks++;
        if (got.size() !== 0 || o_hit_count !== 5'd0) begin
            n_fail++; $display("FAIL vert_above: got %0d hits expected 0", got.size());
        end
    endtask

    task automatic test_overflow();
        int exp_done;
`ifdef SPIRIT_SCAN_EARLY_EXIT_EN
        exp_done = 19;
`else
        exp_done = 514;
`endif
        clear_mem();
        for (int i = 0; i < 20; i++) spr[i] = mk(16'(i * 10), 16'd0, 8'd4, 8'd2);
        run_scan(16'd0, 1'b1, 520, -1);
        n_checks++;
        if (got.size() !== 16) begin
            n_fail++; $display("FAIL ovf_hit_total: got %0d expected 16", got.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (got[i] !== eh(9'(i), 16'(i * 10), 8'd0, 8'd4)) begin
                    n_fail++; $display("FAIL ovf_entry_%0d: got %h expected %h", i, got[i], eh(9'(i), 16'(i * 10), 8'd0, 8'd4));
                end
            end
        end
        n_checks++;
        if (o_overflow !== 1'b1 || o_hit_count !== 5'd16) begin
            n_fail++; $display("FAIL ovf_flags: ovf=%b cnt=%0d expected 1/16", o_overflow, o_hit_count);
        end
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== exp_done) begin
            n_fail++; $display("FAIL ovf_done: cnt=%0d cyc=%0d expected 1/%0d", done_cnt, done_cyc, exp_done);
        end
    endtask

    task automatic test_backpressure();
        hit_t exp [3];
        exp[0] = eh(9'd3, 16'd30, 8'd0, 8'd2);
        exp[1] = eh(9'd7, 16'd70, 8'd5, 8'd3);
        exp[2] = eh(9'd300, 16'd300, 8'd1, 8'd5);
        clear_mem();
        spr[3]   = mk(16'd30, 16'd5, 8'd2, 8'd1);
        spr[7]   = mk(16'd70, 16'd0, 8'd3, 8'd8);
        spr[300] = mk(16'd300, 16'd4, 8'd5, 8'd2);
        run_scan(16'd5, 1'b0, 520, -1);
        n_checks++;
        if (ovf_c1 !== 1'b0) begin
            n_fail++; $display("FAIL bp_overflow_cleared: got %b expected 0", ovf_c1);
        end
        n_checks++;
        if (got.size() !== 0 || o_hit_count !== 5'd3 || o_hit_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_held: popped=%0d cnt=%0d valid=%b expected 0/3/1", got.size(), o_hit_count, o_hit_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); i_hit_ready = 1'b1; #1;
            n_checks++;
            if (o_hit_valid !== 1'b1 || {o_hit_idx, o_hit_x, o_hit_row, o_hit_width} !== exp[i]) begin
                n_fail++; $display("FAIL bp_drain_%0d: valid=%b got %h expected %h", i, o_hit_valid, {o_hit_idx, o_hit_x, o_hit_row, o_hit_width}, exp[i]);
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if (o_hit_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_empty: valid=%b expected 0", o_hit_valid);
        end
        i_hit_ready = 1'b0;
    endtask

    task automatic test_restart();
        clear_mem();
        spr[5] = mk(16'd100, 16'd10, 8'd8, 8'd4);
        run_scan(16'd12, 1'b0, 720, 200);
        n_checks++;
        if (valid_before_rs !== 1'b1 || valid_rs !== 1'b0 || cnt_rs !== 5'd0 || idx_rs !== 9'd0) begin
            n_fail++; $display("FAIL restart_clear: pre_valid=%b valid=%b cnt=%0d idx=%0d expected 1/0/0/0", valid_before_rs, valid_rs, cnt_rs, idx_rs);
        end
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== 714) begin
            n_fail++; $display("FAIL restart_done: cnt=%0d cyc=%0d expected 1/714", done_cnt, done_cyc);
        end
        n_checks++;
        if (o_hit_count !== 5'd1 || o_hit_valid !== 1'b1 || o_hit_idx !== 9'd5) begin
            n_fail++; $display("FAIL restart_rescan: cnt=%0d valid=%b idx=%0d expected 1/1/5", o_hit_count, o_hit_valid, o_hit_idx);
        end
    endtask

    task automatic test_reset_mid_scan();
        int dones;
        dones = 0;
        clear_mem();
        spr[5] = mk(16'd100, 16'd10, 8'd8, 8'd4);
        @(negedge clk);
        i_line_start = 1'b1; i_line_y = 16'd12; i_hit_ready = 1'b0;
        for (int c = 1; c < 50; c++) begin
            @(negedge clk); i_line_start = 1'b0;
        end
        #1;
        n_checks++;
        if (o_busy !== 1'b1 || o_hit_valid !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: busy=%b valid=%b expected 1/1", o_busy, o_hit_valid);
        end
        @(negedge clk); i_rst_n = 1'b0; #1;
        n_checks++;
        if (all_outs() !== 59'd0) begin
            n_fail++; $display("FAIL midrst_outputs: got %h expected 0", all_outs());
        end
        @(negedge clk); @(negedge clk); i_rst_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk); #1;
            if (o_done || o_busy) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", dones);
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_vertical();
        test_overflow();
        test_backpressure();
        test_restart();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
